// File: rtl/mplc_data_arb_pkg.sv
// mplc_data_arb_pkg
// Shared constants for the multi-core logic unit data-memory arbiter.
//   NCoreDefault : default number of bit-logic cores sharing the data RAM
//   DaWDefault   : default data-address width
//   StatW        : width of the optional per-core wait counters
package mplc_data_arb_pkg;

  localparam int unsigned NCoreDefault = 4;
  localparam int unsigned DaWDefault   = 12;
  localparam int unsigned StatW        = 16;

endpackage

// File: rtl/mplc_rr_pick.sv
// mplc_rr_pick
// Combinational round-robin picker. Scans req starting at ptr and wrapping modulo N_CORE;
// g is the first requesting index found, valid is set when any request exists.
// Works for any N_CORE >= 2, including non-powers of two.
//   req   in  N_CORE  request vector
//   ptr   in  PW      scan start index (0..N_CORE-1)
//   g     out PW      winning index (0 when no request)
//   valid out 1       at least one request present
module mplc_rr_pick #(
  parameter int unsigned N_CORE = 4,
  parameter int unsigned PW     = $clog2(N_CORE)
) (
  input  logic [N_CORE-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     g,
  output logic              valid
);

  localparam int unsigned SW = PW + 1;

  logic [SW-1:0] idx;

  // Walk the offsets from the far end back to zero so the last hit written is the one
  // closest to ptr, i.e. the round-robin winner.
  always_comb begin
    g     = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N_CORE - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + SW'(k);
      if (idx >= SW'(N_CORE)) begin
        idx = idx - SW'(N_CORE);
      end
      if (req[idx[PW-1:0]]) begin
        g     = idx[PW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mplc_data_arb.sv
// mplc_data_arb
// Round-robin arbiter sharing one single-port, bit-wide synchronous data RAM between N_CORE
// bit-logic cores. At most one core is granted per cycle, combinationally in the cycle of the
// request; losers see C_RDY low and retry next cycle. Read data returns one cycle after the
// grant (bypassed from M_Q) and is then held per core.
//
// Optional build macro MPLC_ARB_STATS_EN adds per-core saturating wait counters.
//
// Ports:
//   CLK        in   system clock
//   CLR_N      in   asynchronous active-low reset
//   RUN        in   scan-run enable, low freezes the arbiter
//   STAT_SEL   in   counter select             (MPLC_ARB_STATS_EN only)
//   STAT_WAIT  out  selected wait counter      (MPLC_ARB_STATS_EN only)
//   C_OE       in   per-core read request
//   C_WE       in   per-core write request
//   C_A        in   per-core address, core i at [i*DA_W +: DA_W]
//   C_DO       in   per-core write data
//   C_RDY      out  per-core ready, one-hot or zero
//   C_DI       out  per-core read data
//   M_A        out  memory address
//   M_RE       out  memory read strobe
//   M_WE       out  memory write strobe
//   M_WD       out  memory write data
//   M_Q        in   memory read data, valid one cycle after M_RE
module mplc_data_arb
  import mplc_data_arb_pkg::*;
#(
  parameter int unsigned N_CORE = NCoreDefault,
  parameter int unsigned DA_W   = DaWDefault
) (
  input  logic                        CLK,
  input  logic                        CLR_N,
  input  logic                        RUN,
`ifdef MPLC_ARB_STATS_EN
  input  logic [$clog2(N_CORE)-1:0]   STAT_SEL,
  output logic [StatW-1:0]            STAT_WAIT,
`endif
  input  logic [N_CORE-1:0]           C_OE,
  input  logic [N_CORE-1:0]           C_WE,
  input  logic [N_CORE*DA_W-1:0]      C_A,
  input  logic [N_CORE-1:0]           C_DO,
  output logic [N_CORE-1:0]           C_RDY,
  output logic [N_CORE-1:0]           C_DI,
  output logic [DA_W-1:0]             M_A,
  output logic                        M_RE,
  output logic                        M_WE,
  output logic                        M_WD,
  input  logic                        M_Q
);

  localparam int unsigned PW = $clog2(N_CORE);

  logic [N_CORE-1:0] req;
  logic [PW-1:0]     g;
  logic              valid;
  logic              grant;
  logic              is_wr;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [PW-1:0]     rd_id_q, rd_id_d;
  logic [N_CORE-1:0] di_hold_q, di_hold_d;

  assign req = C_OE | C_WE;

  mplc_rr_pick #(
    .N_CORE (N_CORE),
    .PW     (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .g     (g),
    .valid (valid)
  );

  // CLR_N gates the grant so nothing reaches the RAM while reset is held.
  assign grant = valid & RUN & CLR_N;
  assign is_wr = C_WE[g];

  // Grant-cycle memory port and ready.
  always_comb begin
    C_RDY = '0;
    M_A   = '0;
    M_RE  = 1'b0;
    M_WE  = 1'b0;
    M_WD  = 1'b0;
    if (grant) begin
      C_RDY[g] = 1'b1;
      M_A      = C_A[g*DA_W +: DA_W];
      M_WE     = is_wr;
      M_RE     = ~is_wr;
      M_WD     = C_DO[g];
    end
  end

  // Pointer moves past the winner; dropping RUN restarts the rotation at core 0.
  always_comb begin
    ptr_d = ptr_q;
    if (!RUN) begin
      ptr_d = '0;
    end else if (grant) begin
      ptr_d = (g == PW'(N_CORE - 1)) ? '0 : g + 1'b1;
    end
  end

  // Read return: one pending read in flight, bypassed to its core and captured into the hold.
  // A pending read completes even if RUN has dropped meanwhile.
  always_comb begin
    rd_pend_d = grant & ~is_wr;
    rd_id_d   = (grant & ~is_wr) ? g : rd_id_q;
    di_hold_d = di_hold_q;
    C_DI      = di_hold_q;
    if (rd_pend_q) begin
      di_hold_d[rd_id_q] = M_Q;
      C_DI[rd_id_q]      = M_Q;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
      di_hold_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      di_hold_q <= di_hold_d;
    end
  end

`ifdef MPLC_ARB_STATS_EN
  logic                         run_q;
  logic [N_CORE-1:0][StatW-1:0] wait_q, wait_d;

  // Counters restart on RUN rising; the first cycle of the new run still counts if blocked.
  always_comb begin
    wait_d = wait_q;
    for (int i = 0; i < int'(N_CORE); i++) begin
      if (RUN && !run_q) begin
        wait_d[i] = '0;
      end
      if (RUN && req[i] && !C_RDY[i] && (wait_d[i] != '1)) begin
        wait_d[i] = wait_d[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      run_q  <= 1'b0;
      wait_q <= '0;
    end else begin
      run_q  <= RUN;
      wait_q <= wait_d;
    end
  end

  // Out-of-range selects (non-power-of-two N_CORE) read as zero.
  assign STAT_WAIT = (32'(STAT_SEL) < N_CORE) ? wait_q[STAT_SEL] : '0;
`endif

endmodule

// File: tb/tb_mplc_data_arb.sv
module tb_mplc_data_arb;

  localparam int N  = 4;
  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            clr_n;
  logic            run;
  logic [N-1:0]    c_oe, c_we, c_do;
  logic [N*AW-1:0] c_a;
  logic [N-1:0]    c_rdy, c_di;
  logic [AW-1:0]   m_a;
  logic            m_re, m_we, m_wd;
  logic            m_q = 1'b0;
`ifdef MPLC_ARB_STATS_EN
  logic [1:0]      stat_sel = 2'd2;
  logic [15:0]     stat_wait;
`endif

  // Bit-wide RAM: 0x001 and 0x010 hold 1, everything else 0.
  logic [4095:0]   mem = 4096'h10002;
  logic [4095:0]   ref_mem;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mplc_data_arb u_dut (
    .CLK       (clk),
    .CLR_N     (clr_n),
    .RUN       (run),
`ifdef MPLC_ARB_STATS_EN
    .STAT_SEL  (stat_sel),
    .STAT_WAIT (stat_wait),
`endif
    .C_OE      (c_oe),
    .C_WE      (c_we),
    .C_A       (c_a),
    .C_DO      (c_do),
    .C_RDY     (c_rdy),
    .C_DI      (c_di),
    .M_A       (m_a),
    .M_RE      (m_re),
    .M_WE      (m_we),
    .M_WD      (m_wd),
    .M_Q       (m_q)
  );

  always @(posedge clk) begin
    if (m_we) mem[m_a] <= m_wd;
    if (m_re) m_q <= mem[m_a];
  end

  typedef struct {
    logic        run;
    logic [3:0]  oe, we, dout;
    logic [47:0] a;
    logic [3:0]  rdy;
    logic [11:0] ma;
    logic        re, wen, wd;
    logic [3:0]  di;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [47:0] pa(input logic [11:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [47:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] o, w, d, input logic [47:0] a);
    run  = r;
    c_oe = o;
    c_we = w;
    c_do = d;
    c_a  = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    drive(1'b1, 4'h0, 4'h0, 4'h0, 48'h0);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Reference model state
  int           m_ptr;
  logic [N-1:0] m_hold;
  logic         m_pend;
  int           m_id;
  logic         m_data;

  initial begin
    // Directed table, applied one row per cycle from reset (pointer starts at 0).
    tbl[0]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, pa(0, 0, 12'h010, 0),
                4'b0010, 12'h010, 1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 48'h0,
                4'b0000, 12'h000, 1'b0, 1'b0, 1'b0, 4'b0010};
    tbl[2]  = '{1'b1, 4'b0000, 4'b0001, 4'b0001, pa(0, 0, 0, 12'h005),
                4'b0001, 12'h005, 1'b0, 1'b1, 1'b1, 4'b0010};
    tbl[3]  = '{1'b1, 4'b1000, 4'b0000, 4'b0000, pa(12'h005, 0, 0, 0),
                4'b1000, 12'h005, 1'b1, 1'b0, 1'b0, 4'b0010};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 48'h0,
                4'b0000, 12'h000, 1'b0, 1'b0, 1'b0, 4'b1010};
    tbl[5]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, pa(0, 0, 12'h010, 0),
                4'b0010, 12'h010, 1'b1, 1'b0, 1'b0, 4'b1010};
    tbl[6]  = '{1'b1, 4'b1001, 4'b0000, 4'b0000, pa(12'h002, 0, 0, 12'h001),
                4'b1000, 12'h002, 1'b1, 1'b0, 1'b0, 4'b1010};
    tbl[7]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, pa(0, 0, 0, 12'h001),
                4'b0001, 12'h001, 1'b1, 1'b0, 1'b0, 4'b0010};
    tbl[8]  = '{1'b0, 4'b0110, 4'b0000, 4'b0000, pa(0, 12'h003, 12'h010, 0),
                4'b0000, 12'h000, 1'b0, 1'b0, 1'b0, 4'b0011};
    tbl[9]  = '{1'b1, 4'b0011, 4'b0000, 4'b0000, pa(0, 0, 12'h010, 12'h004),
                4'b0001, 12'h004, 1'b1, 1'b0, 1'b0, 4'b0011};
    tbl[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 48'h0,
                4'b0000, 12'h000, 1'b0, 1'b0, 1'b0, 4'b0010};

    // Reset state, with requests present that must be ignored.
    clr_n = 1'b0;
    drive(1'b1, 4'hF, 4'h0, 4'h0, pa(12'h7, 12'h6, 12'h5, 12'h4));
    #12;
    chk("rst_rdy", 0, 48'(c_rdy), 48'h0);
    chk("rst_m", 0, {m_a, m_re, m_we, m_wd}, 48'h0);
    chk("rst_di", 0, 48'(c_di), 48'h0);
    @(negedge clk);
    clr_n = 1'b1;
    drive(1'b1, 4'h0, 4'h0, 4'h0, 48'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(tbl[i].run, tbl[i].oe, tbl[i].we, tbl[i].dout, tbl[i].a);
      #1;
      chk("tbl_rdy", i, 48'(c_rdy), 48'(tbl[i].rdy));
      chk("tbl_ma", i, 48'(m_a), 48'(tbl[i].ma));
      chk("tbl_strobe", i, {m_re, m_we, m_wd}, {tbl[i].re, tbl[i].wen, tbl[i].wd});
      chk("tbl_di", i, 48'(c_di), 48'(tbl[i].di));
    end

    // Reset pulsed the cycle after a read grant: pending read dropped, C_DI cleared.
    @(negedge clk);
    drive(1'b1, 4'b0100, 4'b0000, 4'b0000, pa(0, 12'h010, 0, 0));
    #1 chk("mid_grant", 0, 48'(c_rdy), 48'h4);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("mid_di", 0, 48'(c_di), 48'h0);
    chk("mid_rdy", 0, 48'(c_rdy), 48'h0);
    chk("mid_re", 0, 48'(m_re), 48'h0);
    @(negedge clk);
    clr_n = 1'b1;
    drive(1'b1, 4'h0, 4'h0, 4'h0, 48'h0);
    #1 chk("mid_di_after", 0, 48'(c_di), 48'h0);

    // All cores requesting continuously: strict rotation 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 4'hF, 4'h0, 4'h0, 48'h0);
      #1 chk("rot", i, 48'(c_rdy), 48'(4'b0001 << (i % 4)));
`ifdef MPLC_ARB_STATS_EN
      // Core 2 lost cycles 0,1,3,4,5 before this point.
      if (i == 7) chk("stat_wait", i, 48'(stat_wait), 48'd5);
`endif
    end

    // Randomized run against the behavioural model.
    do_reset();
    ref_mem = mem;
    m_ptr = 0; m_hold = '0; m_pend = 1'b0; m_id = 0; m_data = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic [3:0]  r_oe, r_we, r_do, e_rdy, e_di;
      logic [47:0] r_a;
      logic        r_run, found, e_re, e_we, e_wd;
      logic [11:0] e_ma;
      int          eg;
      @(negedge clk);
      r_run = ($urandom % 8) != 0;
      for (int i = 0; i < N; i++) begin
        int kind;
        kind = $urandom % 4;
        r_oe[i] = (kind == 1);
        r_we[i] = (kind == 2);
        r_do[i] = 1'($urandom % 2);
        r_a[i*AW +: AW] = 12'($urandom % 16);
      end
      drive(r_run, r_oe, r_we, r_do, r_a);

      e_di = m_hold;
      if (m_pend) e_di[m_id] = m_data;
      found = 1'b0;
      eg = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && r_run && (r_oe[idx] || r_we[idx])) begin
          found = 1'b1;
          eg = idx;
        end
      end
      e_rdy = '0; e_ma = '0; e_re = 1'b0; e_we = 1'b0; e_wd = 1'b0;
      if (found) begin
        e_rdy[eg] = 1'b1;
        e_ma = r_a[eg*AW +: AW];
        e_we = r_we[eg];
        e_re = !r_we[eg];
        e_wd = r_do[eg];
      end

      #1;
      chk("rnd_rdy", c, 48'(c_rdy), 48'(e_rdy));
      chk("rnd_ma", c, 48'(m_a), 48'(e_ma));
      chk("rnd_strobe", c, {m_re, m_we, m_wd}, {e_re, e_we, e_wd});
      chk("rnd_di", c, 48'(c_di), 48'(e_di));

      if (m_pend) m_hold[m_id] = m_data;
      m_pend = found && !r_we[eg];
      if (m_pend) begin
        m_id = eg;
        m_data = ref_mem[e_ma];
      end
      if (found && r_we[eg]) ref_mem[e_ma] = r_do[eg];
      m_ptr = found ? (eg + 1) % N : (r_run ? m_ptr : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
